im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//   Writer side of the instruction memory. Receives a byte stream over a valid/ready
//   handshake, assembles big-endian 32-bit words and writes them sequentially into
//   the instruction memory, starting at the fetch reset address.
//   Holds the CPU in reset (cpu_hold) until the program image is fully written.
//   Sits between the host/debug byte link and the instruction memory write port.
// PARAMETERS
//   BASE_ADDR  32'h00003000  byte address of the first instruction word written
//   DEPTH      1024          instruction memory capacity in words (max legal count)
//   CNT_W      11            width of word counters; must hold the value DEPTH
// PORTS
//   clk           in   1      system clock, all state updates on posedge
//   reset         in   1      synchronous, active-high reset
//   in_valid      in   1      in_data holds a valid byte this cycle
//   in_data       in   8      stream byte
//   in_ready      out  1      loader accepts a byte this cycle (transfer = in_valid & in_ready)
//   im_we         out  1      one-cycle instruction memory write strobe
//   im_addr       out  32     byte address of the write (word aligned)
//   im_wdata      out  32     instruction word to write
//   cpu_hold      out  1      keep the CPU/PC in reset while high
//   done          out  1      image fully written; sticky until reset
//   err           out  1      bad header word count; sticky until reset
//   words_loaded  out  CNT_W  number of words written so far
// BEHAVIOUR
//   Reset values: state=HDR, in_ready=1, im_we=0, im_addr=BASE_ADDR, im_wdata=0,
//     cpu_hold=1, done=0, err=0, words_loaded=0, byte counter=0, partial word=0.
//   Stream format: one header word N (the word count), then N instruction words.
//     Every word is 4 bytes, MSB first: 1st byte -> [31:24] ... 4th byte -> [7:0].
//   A 2-bit byte counter advances on each transfer and wraps 3->0 on the 4th byte.
//   States:
//     HDR  : in_ready=1. On the 4th byte: latch N. If N==0 or N>DEPTH -> ERR,
//            otherwise -> DATA.
//     DATA : in_ready=1. On the 4th byte of word k (k = 0..N-1): in the next cycle,
//            im_we=1 for exactly one cycle, im_addr=BASE_ADDR+4*k, and
//            im_wdata=assembled word. words_loaded increments in that same cycle.
//            When the strobe for word N-1 fires, the next state is DONE.
//     DONE : in_ready=0, done=1, cpu_hold=0. Remains in DONE until reset.
//     ERR  : in_ready=0, err=1, cpu_hold=1, im_we=0. Remains in ERR until reset.
//   Latency: 1 cycle from the 4th-byte handshake to the im_we pulse.
//     cpu_hold falls and done rises on the cycle after the last im_we pulse.
//   A byte may be accepted in the same cycle as an im_we pulse, so back-to-back
//     streaming needs no stall. in_ready does not depend on in_valid.
//   Bytes offered while in_ready=0 (DONE/ERR) are not consumed and have no effect.
//   Reset mid-operation: any partial word and the count are discarded. The next
//     cycle shows reset values, and no im_we is issued for the interrupted word.
//   im_addr/im_wdata hold their last values when im_we=0.
//   Address arithmetic is 32-bit unsigned. k*4 never exceeds (DEPTH-1)*4.
// TESTING
//   1. Reset, then bytes 00 00 00 02 | 34 08 00 05 | 03 E0 00 08 -> im_we at 0x3000=34080005,
//      then at 0x3004=03E00008; done=1 and cpu_hold=0 on the cycle after the 2nd pulse.
//   2. Header 00 00 00 00 -> err=1, in_ready=0, cpu_hold=1, no im_we; same result for
//      header 00 00 04 01 (1025 > DEPTH).
//   3. Header N=1024 with in_valid always high -> 1024 pulses; the last is at 0x3FFC;
//      words_loaded=1024; then done=1.
//   4. N=3 with in_valid toggled randomly -> words and addresses are identical to the
//      gap-free case; im_we fires only after the 4th byte of each word.
//   5. Reset asserted after 2 bytes of data word 1 -> next cycle all outputs are at reset
//      values; a fresh N=1 image then loads at 0x3000.
//   6. After done, bytes are offered -> in_ready=0, no im_we, done stays 1.

Source files
------------

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//   Writer side of the instruction memory. Takes a byte stream over a
//   valid/ready handshake and packs it into big-endian 32-bit words. The first
//   word is a header holding the image length N; the next N words are written
//   one after another into instruction memory, starting at BASE_ADDR. The CPU
//   is held in reset (cpu_hold) until the whole image is in memory.
//
// Ports
//   clk           system clock, all state on posedge
//   reset         synchronous, active-high
//   in_valid      in_data carries a byte this cycle
//   in_data       stream byte, MSB of each word first
//   in_ready      loader accepts a byte (transfer = in_valid & in_ready)
//   im_we         one-cycle instruction memory write strobe
//   im_addr       word-aligned byte address of the write
//   im_wdata      instruction word being written
//   cpu_hold      keep CPU/PC in reset while high
//   done          image fully written, sticky until reset
//   err           header count was 0 or larger than DEPTH, sticky until reset
//   words_loaded  number of words written so far
// -----------------------------------------------------------------------------
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024,
  parameter int          CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [23:0]      partial;   // first three bytes of the word in flight
  logic [CNT_W-1:0] n_words;   // image length from the header

  logic        xfer;
  logic        last_byte;
  logic [31:0] word_full;      // word as it stands once the current byte lands

  assign xfer      = in_valid & in_ready;
  assign last_byte = xfer && (byte_cnt == 2'd3);
  assign word_full = {partial, in_data};

  // in_ready, im_we, cpu_hold, done and err are all registers so nothing
  // downstream sees a combinational path from in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_HDR;
      byte_cnt     <= 2'd0;
      partial      <= 24'd0;
      n_words      <= '0;
      in_ready     <= 1'b1;
      im_we        <= 1'b0;
      im_addr      <= BASE_ADDR;
      im_wdata     <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      im_we <= 1'b0;

      // Byte assembly runs in every accepting state; the shifted-out top byte
      // is simply dropped, so no clear is needed between words.
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        partial  <= {partial[15:0], in_data};
      end

      case (state)
        S_HDR: begin
          if (last_byte) begin
            if (word_full == 32'd0 || word_full > 32'(DEPTH)) begin
              state    <= S_ERR;
              err      <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              n_words <= word_full[CNT_W-1:0];
              state   <= S_DATA;
            end
          end
        end

        S_DATA: begin
          // words_loaded has already stepped with the strobe, so equality with
          // n_words while im_we is high marks the final word's pulse.
          if (im_we && words_loaded == n_words) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            in_ready <= 1'b0;
          end else if (last_byte) begin
            im_we        <= 1'b1;
            im_addr      <= BASE_ADDR + (32'(words_loaded) << 2);
            im_wdata     <= word_full;
            words_loaded <= words_loaded + 1'b1;
          end
        end

        // Terminal until reset; in_ready is low so nothing is consumed.
        S_DONE: ;
        S_ERR:  ;
        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 1024;
  localparam int          CNT_W = 11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             in_ready;
  logic             im_we;
  logic [31:0]      im_addr;
  logic [31:0]      im_wdata;
  logic             cpu_hold;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] words_loaded;

  im_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes and byte-acceptance times
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_wl[$];
  int          got_cyc[$];
  logic        got_hold[$];
  int          acc_cyc[$];
  bit          done_seen;
  int          done_cyc;

  // Reference model output and stimulus
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_n;
  logic [7:0]  stim[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (im_we) begin
        got_addr.push_back(im_addr);
        got_data.push_back(im_wdata);
        got_wl.push_back(int'(words_loaded));
        got_cyc.push_back(cyc);
        got_hold.push_back(cpu_hold);
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic clear_obs();
    got_addr.delete(); got_data.delete(); got_wl.delete();
    got_cyc.delete(); got_hold.delete(); acc_cyc.delete();
    done_seen = 1'b0;
    done_cyc  = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
  endtask

  // Header n followed by n random words, big-endian.
  task automatic make_image(input int n);
    logic [31:0] w;
    stim.delete();
    w = n;
    for (int b = 3; b >= 0; b--) stim.push_back(w[b*8 +: 8]);
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      for (int b = 3; b >= 0; b--) stim.push_back(w[b*8 +: 8]);
    end
  endtask

  // Model: word k of the image lands at BASE + 4k.
  task automatic build_exp();
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_n = (int'(stim[0]) << 24) | (int'(stim[1]) << 16) | (int'(stim[2]) << 8) | int'(stim[3]);
    for (int k = 0; k < exp_n && (4 * k + 7) < stim.size(); k++) begin
      w = {stim[4*k+4], stim[4*k+5], stim[4*k+6], stim[4*k+7]};
      exp_addr.push_back(BASE + 32'(4 * k));
      exp_data.push_back(w);
    end
  endtask

  // Drive stim, idling on gap_pct percent of cycles. Entered on a negedge.
  task automatic send(input int gap_pct);
    int i = 0;
    int budget = stim.size() * 20 + 100;
    int c0;
    bit rdy;
    while (i < stim.size() && budget > 0) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = stim[i];
      end
      rdy = in_ready;
      c0  = cyc;
      @(posedge clk);
      if (in_valid && rdy) begin
        acc_cyc.push_back(c0 + 1);
        i++;
      end
      @(negedge clk);
      budget--;
    end
    in_valid = 1'b0;
    checks++;
    if (i != stim.size()) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d of %0d bytes", i, stim.size());
    end
  endtask

  // Drives the current stim as one image and checks every write against the model.
  task automatic test_image(input string name, input int gap_pct, input bit rst);
    if (rst) do_reset();
    else clear_obs();
    build_exp();
    send(gap_pct);
    repeat (4) @(negedge clk);

    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, got_addr.size(), exp_addr.size());
    end
    for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
      checks++;
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
        errors++;
        $display("FAIL %s write[%0d]: got %h=%h want %h=%h", name, k,
                 got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
      checks++;
      if (got_wl[k] != k + 1 || got_hold[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s count_at_pulse[%0d]: words_loaded %0d hold %b want %0d hold 1",
                 name, k, got_wl[k], got_hold[k], k + 1);
      end
      checks++;
      if ((4 * k + 7) >= acc_cyc.size() || got_cyc[k] != acc_cyc[4*k+7]) begin
        errors++;
        $display("FAIL %s latency[%0d]: pulse at cycle %0d, 4th byte accepted at %0d",
                 name, k, got_cyc[k], ((4 * k + 7) < acc_cyc.size()) ? acc_cyc[4*k+7] : -1);
      end
    end
    checks++;
    if (got_cyc.size() == 0 || !done_seen || done_cyc != got_cyc[got_cyc.size()-1] + 1) begin
      errors++;
      $display("FAIL %s done_timing: done at %0d last pulse at %0d", name, done_cyc,
               (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : -1);
    end
    checks++;
    if ({done, cpu_hold, in_ready, err, im_we} !== 5'b10000 || int'(words_loaded) != exp_n) begin
      errors++;
      $display("FAIL %s final: done %b hold %b rdy %b err %b we %b wl %0d want 1 0 0 0 0 %0d",
               name, done, cpu_hold, in_ready, err, im_we, words_loaded, exp_n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, im_we, cpu_hold, done, err} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_flags: rdy/we/hold/done/err=%b want 10100",
               {in_ready, im_we, cpu_hold, done, err});
    end
    checks++;
    if (im_addr !== BASE || im_wdata !== 32'd0 || words_loaded !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h wl %0d want %h 0 0",
               im_addr, im_wdata, words_loaded, BASE);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [12] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h05,
                               8'h03, 8'hE0, 8'h00, 8'h08};
    stim.delete();
    foreach (bytes[i]) stim.push_back(bytes[i]);
    test_image("basic", 0, 1'b1);
    checks++;
    if (got_data.size() != 2 || got_data[0] !== 32'h3408_0005 || got_data[1] !== 32'h03E0_0008
        || got_addr[1] !== 32'h0000_3004) begin
      errors++;
      $display("FAIL basic_words: %0d writes, expected 3000=34080005 3004=03e00008", got_data.size());
    end
  endtask

  // Runs straight after test_basic while the loader sits in DONE.
  task automatic test_after_done();
    int n0 = got_addr.size();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || im_we !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL after_done[%0d]: rdy %b we %b done %b want 0 0 1", i, in_ready, im_we, done);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got_addr.size() != n0) begin
      errors++;
      $display("FAIL after_done_writes: got %0d extra writes want 0", got_addr.size() - n0);
    end
  endtask

  task automatic test_bad_header();
    logic [31:0] hdrs [2] = '{32'd0, 32'd1025};
    for (int h = 0; h < 2; h++) begin
      do_reset();
      stim.delete();
      for (int b = 3; b >= 0; b--) stim.push_back(hdrs[h][b*8 +: 8]);
      send(0);
      checks++;
      if ({err, in_ready, cpu_hold, done} !== 4'b1010) begin
        errors++;
        $display("FAIL bad_hdr_%0d: err %b rdy %b hold %b done %b want 1 0 1 0",
                 hdrs[h], err, in_ready, cpu_hold, done);
      end
      for (int i = 0; i < 6; i++) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (got_addr.size() != 0 || err !== 1'b1 || words_loaded !== '0) begin
        errors++;
        $display("FAIL bad_hdr_%0d_after: writes %0d err %b wl %0d want 0 1 0",
                 hdrs[h], got_addr.size(), err, words_loaded);
      end
    end
  endtask

  task automatic test_full();
    make_image(DEPTH);
    test_image("full", 0, 1'b1);
    checks++;
    if (got_addr.size() != DEPTH || got_addr[DEPTH-1] !== 32'h0000_3FFC) begin
      errors++;
      $display("FAIL full_last_addr: %0d writes, last addr %h want 3ffc", got_addr.size(),
               (got_addr.size() > 0) ? got_addr[got_addr.size()-1] : 32'hx);
    end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) begin
      make_image(3);
      test_image("gaps", 50, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    make_image(2);
    stim = stim[0:9];  // header, word 0, two bytes of word 1
    send(0);
    @(negedge clk);
    checks++;
    if (got_addr.size() != 1) begin
      errors++;
      $display("FAIL mid_pre_writes: got %0d want 1", got_addr.size());
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, im_we, cpu_hold, done, err} !== 5'b10100 || im_addr !== BASE
        || im_wdata !== 32'd0 || words_loaded !== '0) begin
      errors++;
      $display("FAIL mid_reset_vals: flags %b addr %h wdata %h wl %0d",
               {in_ready, im_we, cpu_hold, done, err}, im_addr, im_wdata, words_loaded);
    end
    reset = 1'b0;
    make_image(1);
    test_image("fresh", 0, 1'b0);
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_basic();
    test_after_done();
    test_bad_header();
    test_full();
    test_gaps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
